// File: rtl/rom_fetch_unit.sv
// ---------------------------------------------------------------------------
// rom_fetch_unit
//   Instruction fetch sequencer for a combinational program ROM. Reads one
//   opcode word plus 0-3 operand words (count = opcode[1:0]) and presents the
//   assembled instruction to the execute stage over a valid/ready handshake.
//   Execute may redirect the program counter at any time with jump.
// ---------------------------------------------------------------------------
module rom_fetch_unit #(
    parameter int              AW       = 16,
    parameter int              DW       = 16,
    parameter logic [AW-1:0]   RESET_PC = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic [AW-1:0] rom_a,
    input  logic [DW-1:0] rom_d,
    output logic [DW-1:0] opcode,
    output logic [DW-1:0] arg0,
    output logic [DW-1:0] arg1,
    output logic [DW-1:0] arg2,
    output logic [1:0]    nargs,
    output logic [AW-1:0] instr_pc,
    output logic          valid,
    input  logic          ready,
    input  logic          jump,
    input  logic [AW-1:0] jump_addr
);

    typedef enum logic [1:0] {
        FETCH_OP  = 2'd0,
        FETCH_ARG = 2'd1,
        PRESENT   = 2'd2
    } state_t;

    state_t        state;
    logic [AW-1:0] pc;
    logic [1:0]    idx;

    // The ROM is addressed straight from the PC register, so neither ready
    // nor jump can reach rom_a combinationally.
    assign rom_a = pc;

    // Fetch sequencer: PC, state, operand index and all instruction outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: every register here, outputs included, gets a reset value so
            // execute never sees stale data from before reset.
            pc       <= RESET_PC;
            state    <= FETCH_OP;
            idx      <= 2'd0;
            valid    <= 1'b0;
            opcode   <= '0;
            arg0     <= '0;
            arg1     <= '0;
            arg2     <= '0;
            nargs    <= 2'd0;
            instr_pc <= '0;
        end else if (jump) begin
            // Redirect wins over everything else this cycle. A handshake that
            // completes on the same edge is still consumed, since valid drops
            // and fetch restarts at the target either way. The presented
            // fields keep their old values; only valid goes low.
            pc    <= jump_addr;
            state <= FETCH_OP;
            idx   <= 2'd0;
            valid <= 1'b0;
        end else begin
            case (state)
                FETCH_OP: begin
                    // NOTE: non-blocking assignments throughout, so every
                    // right-hand side sees the pre-edge register values.
                    opcode   <= rom_d;
                    nargs    <= rom_d[1:0];
                    instr_pc <= pc;
                    arg0     <= '0;
                    arg1     <= '0;
                    arg2     <= '0;
                    pc       <= pc + AW'(1);
                    idx      <= 2'd0;
                    state    <= (rom_d[1:0] == 2'd0) ? PRESENT : FETCH_ARG;
                end
                FETCH_ARG: begin
                    case (idx)
                        2'd0:    arg0 <= rom_d;
                        2'd1:    arg1 <= rom_d;
                        default: arg2 <= rom_d;
                    endcase
                    // PC wraps modulo 2^AW, so operands may straddle the top.
                    pc  <= pc + AW'(1);
                    idx <= idx + 2'd1;
                    if ((idx + 2'd1) == nargs) begin
                        state <= PRESENT;
                    end
                end
                PRESENT: begin
                    // First cycle here raises valid; afterwards hold until
                    // execute accepts. PC already points at the next opcode.
                    if (!valid) begin
                        valid <= 1'b1;
                    end else if (ready) begin
                        valid <= 1'b0;
                        state <= FETCH_OP;
                    end
                end
                // NOTE: the two-bit encoding has one unused value; recover to a
                // clean fetch rather than stalling forever.
                default: begin
                    state <= FETCH_OP;
                    valid <= 1'b0;
                end
            endcase
        end
    end

    // Operand count always mirrors the low opcode bits.
    a_nargs_match : assert property (
        @(posedge clk) disable iff (!rst_n) nargs == opcode[1:0]
    );

    // valid is only ever raised from the presentation state.
    a_valid_in_present : assert property (
        @(posedge clk) disable iff (!rst_n) valid |-> (state == PRESENT)
    );

    // A stalled instruction holds every output and the ROM address.
    a_hold_while_stalled : assert property (
        @(posedge clk) disable iff (!rst_n)
        (valid && !ready && !jump) |=>
            valid && $stable({opcode, arg0, arg1, arg2, nargs, instr_pc, rom_a})
    );

endmodule

// File: tb/tb_rom_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_rom_fetch_unit
//   Scoreboard bench: directed stimulus pushes hand-computed instructions into
//   a queue, and a monitor pops and compares on every accepted handshake.
// ---------------------------------------------------------------------------
module tb_rom_fetch_unit;

    typedef struct packed {
        logic [15:0] opcode;
        logic [15:0] arg0;
        logic [15:0] arg1;
        logic [15:0] arg2;
        logic [1:0]  nargs;
        logic [15:0] instr_pc;
    } instr_t;

    logic        clk;
    logic        rst_n;
    logic [15:0] rom_a;
    logic [15:0] rom_d;
    logic [15:0] opcode;
    logic [15:0] arg0;
    logic [15:0] arg1;
    logic [15:0] arg2;
    logic [1:0]  nargs;
    logic [15:0] instr_pc;
    logic        valid;
    logic        ready;
    logic        jump;
    logic [15:0] jump_addr;

    int          n_checks = 0;
    int          n_fail   = 0;
    instr_t      exp_q[$];
    instr_t      mon_e;
    logic [15:0] rom_img [0:24];

    rom_fetch_unit #(
        .AW       (16),
        .DW       (16),
        .RESET_PC (16'h0000)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rom_a     (rom_a),
        .rom_d     (rom_d),
        .opcode    (opcode),
        .arg0      (arg0),
        .arg1      (arg1),
        .arg2      (arg2),
        .nargs     (nargs),
        .instr_pc  (instr_pc),
        .valid     (valid),
        .ready     (ready),
        .jump      (jump),
        .jump_addr (jump_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational program ROM; everything past the image reads 0.
    initial rom_img = '{16'd2, 16'd0, 16'd104, 16'd2, 16'd12, 16'd96, 16'd2, 16'd0,
                        16'd0, 16'd2, 16'd1, 16'd8, 16'd1, 16'd0, 16'd80, 16'd16,
                        16'd8, 16'd1, 16'd8, 16'd0, 16'd1, 16'd80, 16'd8, 16'd36,
                        16'd145};

    always_comb begin
        rom_d = 16'd0;
        if (rom_a <= 16'd24) rom_d = rom_img[rom_a[4:0]];
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic instr_t mk(input logic [15:0] op, input logic [15:0] a0,
                                  input logic [15:0] a1, input logic [15:0] pc);
        instr_t t;
        t.opcode   = op;
        t.arg0     = a0;
        t.arg1     = a1;
        t.arg2     = 16'd0;
        t.nargs    = op[1:0];
        t.instr_pc = pc;
        return t;
    endfunction

    // Monitor: every handshake that completes on the next edge is scored.
    always @(negedge clk) begin
        if (rst_n && valid && ready) begin
            check("sb_pending", 128'(exp_q.size() != 0), 128'(1));
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                check("opcode",   128'(opcode),   128'(mon_e.opcode));
                check("arg0",     128'(arg0),     128'(mon_e.arg0));
                check("arg1",     128'(arg1),     128'(mon_e.arg1));
                check("arg2",     128'(arg2),     128'(mon_e.arg2));
                check("nargs",    128'(nargs),    128'(mon_e.nargs));
                check("instr_pc", 128'(instr_pc), 128'(mon_e.instr_pc));
            end
        end
    end

    // Counts rising edges until valid is seen just after an edge.
    task automatic wait_valid(input int budget, output int cycles);
        cycles = 0;
        do begin
            @(posedge clk);
            #1;
            cycles++;
        end while (!valid && cycles < budget);
        check("valid_reached", 128'(valid), 128'(1));
    endtask

    task automatic wait_instr(input logic [15:0] pc, input int budget);
        int c = 0;
        do begin
            @(posedge clk);
            #1;
            c++;
        end while (!(valid && instr_pc == pc) && c < budget);
        check("instr_reached", 128'(valid && instr_pc == pc), 128'(1));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"},    128'(valid),    128'(0));
        check({tag, "_rom_a"},    128'(rom_a),    128'(0));
        check({tag, "_opcode"},   128'(opcode),   128'(0));
        check({tag, "_args"},     128'({arg0, arg1, arg2}), 128'(0));
        check({tag, "_nargs"},    128'(nargs),    128'(0));
        check({tag, "_instr_pc"}, 128'(instr_pc), 128'(0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          cyc;
        int          c;
        logic [127:0] snap;

        rst_n     = 1'b1;
        ready     = 1'b0;
        jump      = 1'b0;
        jump_addr = 16'h0000;
        #2 rst_n  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");

        // Test 1: reset release, first two instructions.
        exp_q.push_back(mk(16'd2, 16'd0,  16'd104, 16'd0));
        exp_q.push_back(mk(16'd2, 16'd12, 16'd96,  16'd3));
        exp_q.push_back(mk(16'd2, 16'd0,  16'd0,   16'd6));
        exp_q.push_back(mk(16'd2, 16'd1,  16'd8,   16'd9));
        exp_q.push_back(mk(16'd1, 16'd0,  16'd0,   16'd12));
        exp_q.push_back(mk(16'd80, 16'd0, 16'd0,   16'd14));
        ready = 1'b1;
        rst_n = 1'b1;
        wait_valid(10, cyc);
        check("t1_latency", 128'(cyc), 128'(4));

        // Test 2: run to PC 12, then the zero-operand opcode at 14.
        wait_instr(16'd12, 60);
        @(posedge clk);
        #1;
        check("t2_accepted", 128'(valid), 128'(0));
        wait_valid(10, cyc);
        check("t2_latency", 128'(cyc), 128'(2));
        check("t2_pc", 128'(instr_pc), 128'(16'd14));

        // Test 3: stall with ready low for five cycles.
        ready = 1'b0;
        snap  = 128'({valid, opcode, arg0, arg1, arg2, nargs, instr_pc, rom_a});
        check("t3_rom_a", 128'(rom_a), 128'(16'd15));
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("t3_stable", 128'({valid, opcode, arg0, arg1, arg2, nargs, instr_pc, rom_a}), snap);
        end
        exp_q.push_back(mk(16'd16, 16'd0, 16'd0, 16'd15));
        exp_q.push_back(mk(16'd8,  16'd0, 16'd0, 16'd16));
        exp_q.push_back(mk(16'd1,  16'd8, 16'd0, 16'd17));
        exp_q.push_back(mk(16'd0,  16'd0, 16'd0, 16'd19));
        ready = 1'b1;
        @(posedge clk);
        #1;
        check("t3_accepted", 128'(valid), 128'(0));

        // Test 4: jump to 24 while fetching the operand of the opcode at 20.
        c = 0;
        while (rom_a != 16'd21 && c < 100) begin
            @(posedge clk);
            #1;
            c++;
        end
        check("t4_in_fetch_arg", 128'({rom_a, valid}), 128'({16'd21, 1'b0}));
        exp_q.push_back(mk(16'd145, 16'd0, 16'd0, 16'd24));
        jump      = 1'b1;
        jump_addr = 16'd24;
        @(posedge clk);
        #1;
        jump = 1'b0;
        check("t4_rom_a", 128'(rom_a), 128'(16'd24));
        check("t4_keep_old", 128'({valid, opcode, instr_pc}), 128'({1'b0, 16'd1, 16'd20}));
        wait_valid(10, cyc);
        check("t4_latency", 128'(cyc), 128'(3));

        // Test 5: jump to 0xFFFF on the same edge that accepts the opcode at 24.
        exp_q.push_back(mk(16'd0, 16'd0, 16'd0, 16'hFFFF));
        jump      = 1'b1;
        jump_addr = 16'hFFFF;
        @(posedge clk);
        #1;
        jump = 1'b0;
        check("t5_rom_a", 128'({rom_a, valid}), 128'({16'hFFFF, 1'b0}));
        wait_valid(10, cyc);
        check("t5_latency", 128'(cyc), 128'(2));
        check("t5_wrap", 128'(rom_a), 128'(16'h0000));
        exp_q.push_back(mk(16'd2, 16'd0, 16'd104, 16'd0));
        wait_valid(10, cyc);
        check("t5_after_wrap", 128'({rom_a, instr_pc}), 128'({16'd3, 16'd0}));

        // Test 6: asynchronous reset in the middle of an operand fetch.
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check("t6_in_fetch_arg", 128'({rom_a, opcode, instr_pc}), 128'({16'd4, 16'd2, 16'd3}));
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs("t6_async");
        repeat (2) @(posedge clk);
        #1;
        exp_q.push_back(mk(16'd2, 16'd0,  16'd104, 16'd0));
        exp_q.push_back(mk(16'd2, 16'd12, 16'd96,  16'd3));
        rst_n = 1'b1;
        wait_valid(10, cyc);
        check("t6_latency", 128'(cyc), 128'(4));
        wait_instr(16'd3, 20);
        @(posedge clk);
        #1;
        ready = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check("sb_drained", 128'(exp_q.size()), 128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
